// File: rtl/fnd_counter_ctrl.sv
// fnd_counter_ctrl: N-digit BCD up/down counter with run/stop, clear, wrap pulse and multiplexed 7-segment scan
module fnd_counter_ctrl #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10_000_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_run,
  input  logic                  btn_clear,
  input  logic                  mode,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic                  running,
  output logic [7:0]            fnd_data,
  output logic [DIGITS-1:0]     fnd_com
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [6:0] SEG [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  typedef enum logic {STOP, RUN} state_t;
  state_t state_q, state_d;
  logic [TW-1:0] div_q, div_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] dig_q, dig_d;
  logic [4*DIGITS-1:0] count_q, count_d, inc, dec;
  logic wrap_q, wrap_d, tick, all9, all0, scan_end;
  logic [3:0] cur;
  logic [6:0] seg;
  logic [7:0] fnd_data_q, fnd_data_d;
  logic [DIGITS-1:0] fnd_com_q, fnd_com_d;
  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign running   = state_q == RUN;
  assign fnd_data  = fnd_data_q;
  assign fnd_com   = fnd_com_q;
  // all9/all0 double as the ripple carry/borrow into the next digit
  always_comb begin
    all9 = 1'b1;
    all0 = 1'b1;
    inc  = count_q;
    dec  = count_q;
    for (int k = 0; k < DIGITS; k++) begin
      inc[4*k +: 4] = all9 ? (count_q[4*k +: 4] == 4'd9 ? 4'd0 : count_q[4*k +: 4] + 4'd1) : count_q[4*k +: 4];
      dec[4*k +: 4] = all0 ? (count_q[4*k +: 4] == 4'd0 ? 4'd9 : count_q[4*k +: 4] - 4'd1) : count_q[4*k +: 4];
      all9 = all9 & (count_q[4*k +: 4] == 4'd9);
      all0 = all0 & (count_q[4*k +: 4] == 4'd0);
    end
  end
  always_comb begin
    tick       = state_q == RUN && div_q == TW'(TICK_DIV - 1);
    state_d    = btn_run ? (state_q == RUN ? STOP : RUN) : state_q;
    div_d      = btn_clear ? '0 : state_q == RUN ? (tick ? '0 : div_q + 1'b1) : div_q;
    count_d    = btn_clear ? '0 : tick ? (mode ? dec : inc) : count_q;
    wrap_d     = !btn_clear && tick && (mode ? all0 : all9);
    scan_end   = scan_q == SW'(SCAN_DIV - 1);
    scan_d     = scan_end ? '0 : scan_q + 1'b1;
    dig_d      = scan_end ? (dig_q == DW'(DIGITS - 1) ? '0 : dig_q + 1'b1) : dig_q;
    cur        = count_q[4*dig_q +: 4];
    seg        = cur <= 4'd9 ? SEG[cur] : 7'h7F;
    fnd_data_d = {~(state_q == RUN && dig_q == '0), seg};
    fnd_com_d  = ~(DIGITS'(1) << dig_q);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STOP;
      div_q      <= '0;
      scan_q     <= '0;
      dig_q      <= '0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      fnd_data_q <= 8'hC0;
      fnd_com_q  <= ~DIGITS'(1);
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      scan_q     <= scan_d;
      dig_q      <= dig_d;
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      fnd_data_q <= fnd_data_d;
      fnd_com_q  <= fnd_com_d;
    end
  end
endmodule

// File: doc/fnd_counter_ctrl.md
# fnd_counter_ctrl

Parametrised N-digit BCD up/down counter with a built-in multiplexed 7-segment (FND) scan driver. It is the next generation of the fixed 4-digit 0–9999 counter top: digit count, count rate and scan rate are parameters, and it adds run/stop control, clear, count direction and a wrap indication. It sits directly behind the board button debouncers and drives the FND pins.

## Interface
- DIGITS, 4: number of BCD digits and FND commons (1..8); count range 0 .. 10^DIGITS−1.
- TICK_DIV, 10_000_000: clk cycles per count step (≥2).
- SCAN_DIV, 100_000: clk cycles per displayed digit (≥2).
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high.
- btn_run  input  1  single-cycle pulse; toggles STOP/RUN.
- btn_clear  input  1  single-cycle pulse; zeroes count and tick divider.
- mode  input  1  level; 0 = count up, 1 = count down; sampled at each tick.
- count_bcd  output  4*DIGITS  current count; digit k in bits [4k+3:4k], digit 0 = least significant.
- wrap  output  1  one-cycle pulse when the count wraps.
- running  output  1  1 in RUN state.
- fnd_data  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.
- fnd_com  output  DIGITS  digit commons, active-low, one-hot-low; bit k drives digit k.

## Operation
- FSM states: STOP, RUN. Reset → STOP. btn_run in STOP → RUN; in RUN → STOP. Other inputs do not change state.
- Tick divider: counts 0..TICK_DIV−1 only in RUN; holds its value in STOP. A tick occurs on the cycle the divider equals TICK_DIV−1; the divider then returns to 0.
- On a tick, with mode=0: BCD increment with ripple carry; 9 → 0 with carry. The all-9s value → all-0s and asserts wrap.
- On a tick, with mode=1: BCD decrement with borrow; 0 → 9 with borrow. The all-0s value → all-9s and asserts wrap.
- No digit ever holds a value above 9.
- btn_clear: the next cycle has count = 0 and divider = 0, in either state. The state is unchanged. It suppresses any tick and wrap in the same cycle.
- Simultaneous btn_clear and btn_run: both take effect (cleared and toggled).
- Scan: the scan counter runs 0..SCAN_DIV−1 continuously, independent of FSM state. At terminal count the digit index advances k → k+1, and DIGITS−1 → 0.
- Segment encoding (dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex).
- dp (bit 7) is driven 0 (lit) only while digit 0 is selected and state is RUN. Otherwise it is 1.
- All outputs are registered.

## Timing
- Reset values: count_bcd=0, wrap=0, running=0, fnd_com = all 1s except bit 0 = 0, fnd_data=8'hC0, divider=0, scan counter=0, digit index=0, state=STOP.
- btn_run at cycle n → running changes at n+1. The first tick after entering RUN from a cleared divider occurs at cycle n+TICK_DIV.
- Tick at cycle n → count_bcd and wrap update at n+1. wrap lasts exactly one cycle.
- Consecutive ticks are TICK_DIV cycles apart.
- Digit-index change and count change at cycle n → fnd_com and fnd_data reflect them at n+1. fnd_com and fnd_data always switch on the same edge (no stale-digit glitch).
- Reset asserted mid-count or mid-scan → all reset values on the next edge, regardless of other inputs.
- Changing mode between ticks has no effect until the next tick.

## Test plan
- Reset: DIGITS=4, TICK_DIV=4, SCAN_DIV=2, hold reset 2 cycles → count_bcd=0, fnd_com=4'b1110, fnd_data=8'hC0, running=0, wrap=0.
- Up count: btn_run, mode=0, run 40 cycles → count_bcd=16'h0010 (decimal 10). Each step is exactly 4 cycles apart; digit 0 passes 9→0 with carry into digit 1.
- Up wrap: DIGITS=2, start at 99 (clear, then down-tick once) → next up tick gives 00, and wrap pulses 1 cycle.
- Down count: from 00 with mode=1 → 99 with wrap pulse, then 98 after 4 more cycles.
- Stop/clear: RUN at 37, btn_run → count frozen for 20 cycles. Then btn_clear together with btn_run → count=0 and running=1. The next tick arrives 4 cycles later.
- Scan: run at count 1234 → fnd_com cycles 1110,1101,1011,0111 every 2 cycles, with fnd_data 99(+dp lit → 19),B0,A4,F9. dp is lit only on digit 0 while running; with running=0, digit 0 shows 99.
